// File: rtl/inner_prod_stream.sv
// Streaming inner-product engine: C = sum(A[i]*B[i]) over VEC_LEN elements.
// Signed/unsigned operands, result valid/ready with back-pressure, flush.
module inner_prod_stream #(
  parameter  int DATA_W  = 8,
  parameter  int VEC_LEN = 8,
  parameter  int SIGNED  = 0,
  localparam int OUT_W   = 2*DATA_W+$clog2(VEC_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              in_ready,
  input  logic              flush,
  output logic              valid_out,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  C
);

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam int P_W   = 2*DATA_W;
  localparam int EXT_W = OUT_W-P_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN-1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  c_q, c_d;
  logic              vld_q, vld_d;

  logic [P_W-1:0]        prod_u;
  logic signed [P_W-1:0] prod_s;
  logic [OUT_W-1:0]      prod;
  logic                  is_last;
  logic                  accept;

  // Product of the current element pair, extended to the result width
  always_comb begin
    prod_u = A * B;
    prod_s = $signed(A) * $signed(B);
    if (SIGNED != 0)
      prod = {{EXT_W{prod_s[P_W-1]}}, prod_s};
    else
      prod = {{EXT_W{1'b0}}, prod_u};
  end

  // Only the closing element stalls, and only behind an unconsumed result
  always_comb begin
    is_last  = (cnt_q == LAST);
    in_ready = !(is_last && vld_q && !out_ready);
    accept   = valid_in && in_ready;
  end

  // Next-state: accumulate, close vector, hand off result, flush
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    c_d   = c_q;
    vld_d = vld_q;
    if (vld_q && out_ready)
      vld_d = 1'b0;
    if (flush) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (is_last) begin
        c_d   = acc_q + prod;
        vld_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = (cnt_q == '0) ? prod : acc_q + prod;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      c_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      c_q   <= c_d;
      vld_q <= vld_d;
    end
  end

  assign valid_out = vld_q;
  assign C         = c_q;

endmodule

// File: tb/tb_inner_prod_stream.sv
// Directed bench for inner_prod_stream: unsigned default
// instance plus a SIGNED=1 instance sharing clock and reset.
module tb_inner_prod_stream;

  logic        clk = 0;
  logic        rst_n = 0;

  logic        valid_in = 0;
  logic [7:0]  a = 0, b = 0;
  logic        in_ready;
  logic        flush = 0;
  logic        valid_out;
  logic        out_ready = 1;
  logic [18:0] c;

  logic        s_valid_in = 0;
  logic [7:0]  sa = 0, sb = 0;
  logic        s_in_ready;
  logic        s_valid_out;
  logic [18:0] sc;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  inner_prod_stream dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .A(a), .B(b), .in_ready(in_ready), .flush(flush),
    .valid_out(valid_out), .out_ready(out_ready), .C(c)
  );

  inner_prod_stream #(.SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .valid_in(s_valid_in),
    .A(sa), .B(sb), .in_ready(s_in_ready), .flush(1'b0),
    .valid_out(s_valid_out), .out_ready(1'b1), .C(sc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv);
    valid_in = 1;
    a = av;
    b = bv;
    step();
  endtask

  task automatic test_reset();
    out_ready = 0;
    for (int i = 0; i < 8; i++) drive(8'd1, 8'd1);
    valid_in = 0;
    total++;
    if (valid_out !== 1'b1 || c !== 19'd8)
      $display("FAIL pre_reset_result: vo=%0b C=%0d need vo=1 C=8", valid_out, c);
    else pass_cnt++;
    #2;
    rst_n = 0;
    #1;
    total++;
    if (valid_out !== 1'b0 || c !== 19'd0 || in_ready !== 1'b1)
      $display("FAIL async_reset: vo=%0b C=%0d rdy=%0b need 0/0/1", valid_out, c, in_ready);
    else pass_cnt++;
    step();
    rst_n = 1;
    out_ready = 1;
    step();
  endtask

  task automatic test_defaults();
    for (int i = 0; i < 8; i++) drive(8'd255, 8'd255);
    valid_in = 0;
    total++;
    if (valid_out !== 1'b1 || c !== 19'd520200)
      $display("FAIL max_unsigned: vo=%0b C=%0d need vo=1 C=520200", valid_out, c);
    else pass_cnt++;
    step();
    total++;
    if (valid_out !== 1'b0)
      $display("FAIL single_cycle_valid: vo=%0b need 0", valid_out);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    logic signed [18:0] exp;
    for (int i = 0; i < 8; i++) begin
      s_valid_in = 1; sa = 8'h80; sb = 8'h80;
      step();
    end
    s_valid_in = 0;
    exp = 19'sd131072;
    total++;
    if (s_valid_out !== 1'b1 || sc !== exp)
      $display("FAIL signed_neg_neg: vo=%0b C=%0d need 131072", s_valid_out, $signed(sc));
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      s_valid_in = 1; sa = 8'h80; sb = 8'h7f;
      step();
    end
    s_valid_in = 0;
    exp = -19'sd130048;
    total++;
    if (s_valid_out !== 1'b1 || sc !== exp)
      $display("FAIL signed_neg_pos: vo=%0b C=%0d need -130048", s_valid_out, $signed(sc));
    else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    for (int i = 0; i < 8; i++) drive(8'(i + 1), 8'd1);
    for (int i = 0; i < 7; i++) drive(8'(10 + i), 8'd2);
    valid_in = 1; a = 8'd17; b = 8'd2;
    #1;
    total++;
    if (in_ready !== 1'b0 || valid_out !== 1'b1 || c !== 19'd36)
      $display("FAIL stall_last: rdy=%0b vo=%0b C=%0d need 0/1/36", in_ready, valid_out, c);
    else pass_cnt++;
    step();
    step();
    total++;
    if (in_ready !== 1'b0 || c !== 19'd36)
      $display("FAIL stall_hold: rdy=%0b C=%0d need 0/36", in_ready, c);
    else pass_cnt++;
    out_ready = 1;
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL release_ready: rdy=%0b need 1", in_ready);
    else pass_cnt++;
    step();
    valid_in = 0;
    total++;
    if (valid_out !== 1'b1 || c !== 19'd216)
      $display("FAIL vec2_result: vo=%0b C=%0d need vo=1 C=216", valid_out, c);
    else pass_cnt++;
    step();
    total++;
    if (valid_out !== 1'b0)
      $display("FAIL vec2_consumed: vo=%0b need 0", valid_out);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [18:0] want;
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) drive(8'(i), 8'(i + 1));
      else       drive(8'd3, 8'(i - 8));
      want = (i == 7) ? 19'd168 : 19'd84;
      total++;
      if (valid_out !== (i % 8 == 7))
        $display("FAIL b2b_valid[%0d]: vo=%0b need %0b", i, valid_out, (i % 8 == 7));
      else pass_cnt++;
      if (i % 8 == 7) begin
        total++;
        if (c !== want)
          $display("FAIL b2b_c[%0d]: C=%0d need %0d", i, c, want);
        else pass_cnt++;
      end
    end
    valid_in = 0;
    for (int i = 0; i < 8; i++) begin
      drive(8'(i + 5), 8'd7);
      if (i == 1 || i == 4 || i == 6) begin
        valid_in = 0;
        a = 8'hff; b = 8'hff;
        step();
        step();
      end
    end
    valid_in = 0;
    total++;
    if (valid_out !== 1'b1 || c !== 19'd476)
      $display("FAIL gaps_result: vo=%0b C=%0d need vo=1 C=476", valid_out, c);
    else pass_cnt++;
    step();
    total++;
    if (valid_out !== 1'b0)
      $display("FAIL gaps_consumed: vo=%0b need 0", valid_out);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive(8'd9, 8'd9);
    flush = 1;
    drive(8'd50, 8'd50);
    flush = 0;
    for (int i = 0; i < 8; i++) drive(8'd2, 8'd3);
    valid_in = 0;
    total++;
    if (valid_out !== 1'b1 || c !== 19'd48)
      $display("FAIL flush_result: vo=%0b C=%0d need vo=1 C=48", valid_out, c);
    else pass_cnt++;
    out_ready = 0;
    step();
    drive(8'd4, 8'd4);
    valid_in = 0;
    flush = 1;
    step();
    flush = 0;
    total++;
    if (valid_out !== 1'b1 || c !== 19'd48)
      $display("FAIL flush_keeps_result: vo=%0b C=%0d need vo=1 C=48", valid_out, c);
    else pass_cnt++;
    out_ready = 1;
    step();
    for (int i = 0; i < 8; i++) drive(8'd1, 8'd2);
    valid_in = 0;
    total++;
    if (valid_out !== 1'b1 || c !== 19'd16)
      $display("FAIL post_flush_clean: vo=%0b C=%0d need vo=1 C=16", valid_out, c);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive(8'd9, 8'd9);
    valid_in = 0;
    #2;
    rst_n = 0;
    #1;
    total++;
    if (valid_out !== 1'b0 || c !== 19'd0 || in_ready !== 1'b1)
      $display("FAIL reset_mid: vo=%0b C=%0d rdy=%0b need 0/0/1", valid_out, c, in_ready);
    else pass_cnt++;
    step();
    rst_n = 1;
    step();
    for (int i = 0; i < 8; i++) drive(8'd2, 8'd3);
    valid_in = 0;
    total++;
    if (valid_out !== 1'b1 || c !== 19'd48)
      $display("FAIL reset_result: vo=%0b C=%0d need vo=1 C=48", valid_out, c);
    else pass_cnt++;
    step();
  endtask

  initial begin
    #1;
    total++;
    if (valid_out !== 1'b0 || c !== 19'd0 || in_ready !== 1'b1)
      $display("FAIL reset_state: vo=%0b C=%0d rdy=%0b need 0/0/1", valid_out, c, in_ready);
    else pass_cnt++;
    step();
    rst_n = 1;
    step();
    test_reset();
    test_defaults();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
